// File: rtl/vx_gbar_unit_pkg.sv
// rtl/vx_gbar_unit_pkg.sv - global barrier bus field widths and barrier entry type
// Purpose: shared widths for the gbar request/response fields and the packed
//          per-barrier state record used by vx_gbar_unit.
// Ports:   none (package).
package vx_gbar_unit_pkg;

    // Rounds a zero-width field up to one bit.
    function automatic int gbar_up(input int x);
        return (x == 0) ? 1 : x;
    endfunction

    localparam int GBAR_NB_BITS      = 2;
    localparam int GBAR_NC_BITS      = 2;
    localparam int GBAR_NUM_BARRIERS = 1 << GBAR_NB_BITS;
    localparam int GBAR_NUM_CORES    = 4;

    localparam int GBAR_ID_W   = GBAR_NB_BITS;
    localparam int GBAR_CORE_W = gbar_up(GBAR_NC_BITS);
    // One extra bit so a full house of cores never wraps the counter.
    localparam int GBAR_CNT_W  = GBAR_CORE_W + 1;

    typedef struct packed {
        logic                      open;
        logic [GBAR_CORE_W-1:0]    size_m1;
        logic [GBAR_CNT_W-1:0]     count;
        logic [GBAR_NUM_CORES-1:0] mask;
    } gbar_entry_t;

endpackage

// File: rtl/vx_gbar_unit.sv
// rtl/vx_gbar_unit.sv - global barrier slave: collects core arrivals, broadcasts releases
// Purpose: tracks per-barrier arrival state and pulses a one-cycle release
//          when the expected number of distinct cores has arrived.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   req_valid       arrival request valid (at most one per cycle)
//   req_id          barrier ID
//   req_size_m1     participating cores minus one
//   req_core_id     arriving core
//   req_ready       request accepted when req_valid && req_ready
//   rsp_valid       one-cycle release broadcast, no backpressure
//   rsp_id          released barrier ID
//   dup_err         one-cycle pulse: core arrived twice at an open barrier
//   size_err        one-cycle pulse: req_size_m1 differs from the latched size
module vx_gbar_unit
    import vx_gbar_unit_pkg::*;
#(
    parameter int NUM_BARRIERS = GBAR_NUM_BARRIERS,
    parameter int NUM_CORES    = GBAR_NUM_CORES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic [GBAR_ID_W-1:0]   req_id,
    input  logic [GBAR_CORE_W-1:0] req_size_m1,
    input  logic [GBAR_CORE_W-1:0] req_core_id,
    output logic                   req_ready,
    output logic                   rsp_valid,
    output logic [GBAR_ID_W-1:0]   rsp_id,
    output logic                   dup_err,
    output logic                   size_err
);

    gbar_entry_t entries [NUM_BARRIERS];

    gbar_entry_t cur;
    gbar_entry_t nxt;
    logic        accept;
    logic        release_hit;
    logic        dup_hit;
    logic        size_hit;

    assign accept = req_valid && req_ready;

    // Arrivals are serialized upstream, so one read-modify-write path on the
    // addressed entry is enough.
    always_comb begin
        cur         = entries[req_id];
        nxt         = cur;
        dup_hit     = 1'b0;
        size_hit    = 1'b0;
        release_hit = 1'b0;

        if (!cur.open) begin
            nxt.open               = 1'b1;
            nxt.size_m1            = req_size_m1;
            nxt.mask               = '0;
            nxt.mask[req_core_id]  = 1'b1;
            nxt.count              = GBAR_CNT_W'(1);
        end else begin
            // The first arrival's size stays authoritative; mismatches only flag.
            size_hit = (req_size_m1 != cur.size_m1);
            if (cur.mask[req_core_id]) begin
                dup_hit = 1'b1;
            end else begin
                nxt.mask[req_core_id] = 1'b1;
                nxt.count             = cur.count + GBAR_CNT_W'(1);
            end
        end

        // Uses the post-update count and the freshly latched size on first arrival.
        release_hit = !dup_hit &&
                      (nxt.count == ({1'b0, nxt.size_m1} + GBAR_CNT_W'(1)));
        if (release_hit) begin
            nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_BARRIERS; i++) begin
                entries[i] <= '0;
            end
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            dup_err   <= 1'b0;
            size_err  <= 1'b0;
        end else begin
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            dup_err   <= 1'b0;
            size_err  <= 1'b0;
            if (accept) begin
                entries[req_id] <= nxt;
                rsp_valid       <= release_hit;
                dup_err         <= dup_hit;
                size_err        <= size_hit;
                if (release_hit) begin
                    rsp_id <= req_id;
                end
            end
        end
    end

    // Out-of-range core IDs have no hardware meaning; catch them in simulation.
    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            assert (int'(req_core_id) < NUM_CORES);
        end
    end

endmodule

// File: tb/tb_vx_gbar_unit.sv
// tb/tb_vx_gbar_unit.sv - self-checking bench for vx_gbar_unit
module tb_vx_gbar_unit;
    import vx_gbar_unit_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   req_valid = 1'b0;
    logic [GBAR_ID_W-1:0]   req_id = '0;
    logic [GBAR_CORE_W-1:0] req_size_m1 = '0;
    logic [GBAR_CORE_W-1:0] req_core_id = '0;
    logic                   req_ready;
    logic                   rsp_valid;
    logic [GBAR_ID_W-1:0]   rsp_id;
    logic                   dup_err;
    logic                   size_err;

    always #5 clk = ~clk;

    vx_gbar_unit dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_id      (req_id),
        .req_size_m1 (req_size_m1),
        .req_core_id (req_core_id),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .dup_err     (dup_err),
        .size_err    (size_err)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: each barrier is a set of arrived cores plus its agreed size.
    int arrived [GBAR_NUM_BARRIERS][$];
    bit m_open  [GBAR_NUM_BARRIERS];
    int m_size  [GBAR_NUM_BARRIERS];
    bit m_ready = 1'b0;
    bit e_rsp, e_dup, e_size;
    int e_id;
    int pref_size [GBAR_NUM_BARRIERS];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit v, input int id, input int sz, input int core, input bit rst);
        bit seen;
        e_rsp  = 1'b0;
        e_dup  = 1'b0;
        e_size = 1'b0;
        if (rst) begin
            for (int b = 0; b < GBAR_NUM_BARRIERS; b++) begin
                arrived[b].delete();
                m_open[b] = 1'b0;
                m_size[b] = 0;
            end
            m_ready = 1'b0;
            return;
        end
        if (v && m_ready) begin
            if (!m_open[id]) begin
                m_open[id] = 1'b1;
                m_size[id] = sz;
                arrived[id].delete();
                arrived[id].push_back(core);
            end else begin
                e_size = (sz != m_size[id]);
                seen = 1'b0;
                foreach (arrived[id][k]) if (arrived[id][k] == core) seen = 1'b1;
                if (seen) e_dup = 1'b1;
                else      arrived[id].push_back(core);
            end
            if (!e_dup && arrived[id].size() == m_size[id] + 1) begin
                e_rsp = 1'b1;
                e_id  = id;
                arrived[id].delete();
                m_open[id] = 1'b0;
            end
        end
        m_ready = 1'b1;
    endtask

    task automatic cycle(input bit v, input int id, input int sz, input int core, input bit rst);
        @(negedge clk);
        reset       = rst;
        req_valid   = v;
        req_id      = GBAR_ID_W'(id);
        req_size_m1 = GBAR_CORE_W'(sz);
        req_core_id = GBAR_CORE_W'(core);
        @(posedge clk);
        model_edge(v, id, sz, core, rst);
        #1;
        check_eq("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
        check_eq("dup_err",   32'(dup_err),   32'(e_dup));
        check_eq("size_err",  32'(size_err),  32'(e_size));
        check_eq("req_ready", 32'(req_ready), 32'(m_ready));
        if (e_rsp) check_eq("rsp_id", 32'(rsp_id), 32'(e_id));
        if (rst)   check_eq("rsp_id_reset", 32'(rsp_id), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, 0, 0, 1'b1);
        idle(1);

        // Four cores meet at barrier 2.
        for (int c = 0; c < 4; c++) cycle(1'b1, 2, 3, c, 1'b0);
        idle(2);

        // Size one: each arrival releases on its own.
        cycle(1'b1, 0, 0, 1, 1'b0);
        cycle(1'b1, 0, 0, 1, 1'b0);
        idle(2);

        // Interleaved barriers 1 and 3.
        cycle(1'b1, 1, 1, 0, 1'b0);
        cycle(1'b1, 3, 1, 2, 1'b0);
        cycle(1'b1, 1, 1, 1, 1'b0);
        cycle(1'b1, 3, 1, 3, 1'b0);
        idle(2);

        // Duplicate arrival then completion.
        cycle(1'b1, 1, 1, 0, 1'b0);
        cycle(1'b1, 1, 1, 0, 1'b0);
        cycle(1'b1, 1, 1, 1, 1'b0);
        idle(2);

        // Size mismatch keeps the first latched size.
        cycle(1'b1, 0, 2, 0, 1'b0);
        cycle(1'b1, 0, 1, 1, 1'b0);
        cycle(1'b1, 0, 2, 2, 1'b0);
        idle(2);

        // Reset discards partial arrivals.
        cycle(1'b1, 2, 2, 0, 1'b0);
        cycle(1'b1, 2, 2, 1, 1'b0);
        cycle(1'b0, 0, 0, 0, 1'b1);
        idle(1);
        cycle(1'b1, 2, 2, 0, 1'b0);
        cycle(1'b1, 2, 2, 1, 1'b0);
        cycle(1'b1, 2, 2, 2, 1'b0);
        idle(2);

        // Randomized traffic with mostly consistent sizes and rare resets.
        for (int b = 0; b < GBAR_NUM_BARRIERS; b++) pref_size[b] = $urandom_range(0, 3);
        for (int i = 0; i < 3000; i++) begin
            int id, sz;
            id = $urandom_range(0, GBAR_NUM_BARRIERS - 1);
            sz = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : pref_size[id];
            cycle($urandom_range(0, 3) != 0, id, sz, $urandom_range(0, GBAR_NUM_CORES - 1),
                  $urandom_range(0, 199) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
